// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: decodes IF/ID, forwards EX/MEM/WB results, registers ID/EX.
// Latency: 1 cycle IF/ID -> ID/EX; a load-use pair inserts exactly one bubble.
// Backpressure: ex_hold freezes ID/EX and stalls IF; flush wins and inserts a bubble.
module id_operand_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [31:0]       if_pc,
   output logic              id_stall,
   output logic [REG_AW-1:0] rf_r_reg1,
   output logic [REG_AW-1:0] rf_r_reg2,
   input  logic [DATA_W-1:0] rf_r1_data,
   input  logic [DATA_W-1:0] rf_r2_data,
   input  logic              ex_wr_en,
   input  logic [REG_AW-1:0] ex_w_reg,
   input  logic [DATA_W-1:0] ex_w_data,
   input  logic              mem_wr_en,
   input  logic [REG_AW-1:0] mem_w_reg,
   input  logic [DATA_W-1:0] mem_w_data,
   input  logic              wb_wr_en,
   input  logic [REG_AW-1:0] wb_w_reg,
   input  logic [DATA_W-1:0] wb_w_data,
   input  logic              ex_hold,
   input  logic              flush,
   output logic              idex_valid,
   output logic [31:0]       idex_pc,
   output logic [5:0]        idex_opcode,
   output logic [5:0]        idex_funct,
   output logic [DATA_W-1:0] idex_rs_data,
   output logic [DATA_W-1:0] idex_rt_data,
   output logic [31:0]       idex_imm,
   output logic [REG_AW-1:0] idex_rd,
   output logic              idex_wr_en,
   output logic              idex_is_load,
   output logic              idex_is_store
);

   logic [5:0]        w_op;
   logic [5:0]        w_funct;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic [REG_AW-1:0] w_rd_field;
   logic [REG_AW-1:0] w_dest;
   logic              w_wr_en;
   logic [31:0]       w_imm;
   logic              w_use_rs;
   logic              w_use_rt;
   logic [DATA_W-1:0] w_rs_data;
   logic [DATA_W-1:0] w_rt_data;
   logic              w_load_use;
   logic              w_is_load;
   logic              w_is_store;

   assign w_op       = if_instr[31:26];
   assign w_funct    = if_instr[5:0];
   assign w_rs       = REG_AW'(if_instr[25:21]);
   assign w_rt       = REG_AW'(if_instr[20:16]);
   assign w_rd_field = REG_AW'(if_instr[15:11]);
   assign rf_r_reg1  = w_rs;
   assign rf_r_reg2  = w_rt;
   assign w_is_load  = (w_op == 6'h23);
   assign w_is_store = (w_op == 6'h2B);

   // Destination register and write enable; writes to $0 are suppressed.
   always_comb begin
      w_dest  = '0;
      w_wr_en = 1'b0;
      if (w_op == 6'h00) begin
         w_dest  = w_rd_field;
         w_wr_en = (w_funct != 6'h08);
      end else if ((w_op >= 6'h08 && w_op <= 6'h0F) || w_is_load) begin
         w_dest  = w_rt;
         w_wr_en = 1'b1;
      end else if (w_op == 6'h03) begin
         w_dest  = REG_AW'(31);
         w_wr_en = 1'b1;
      end
      if (w_dest == '0) w_wr_en = 1'b0;
   end

   // Logical immediates (andi/ori/xori) zero-extend, everything else sign-extends.
   always_comb begin
      if (w_op == 6'h0C || w_op == 6'h0D || w_op == 6'h0E) w_imm = {16'h0000, if_instr[15:0]};
      else                                               w_imm = {{16{if_instr[15]}}, if_instr[15:0]};
   end

   // Which source fields the instruction really reads (drives the load-use check only).
   always_comb begin
      w_use_rs = !(w_op == 6'h02 || w_op == 6'h03 || w_op == 6'h0F);
      w_use_rt = (w_op == 6'h00 || w_op == 6'h04 || w_op == 6'h05 || w_op == 6'h2B);
   end

   // rs operand: $0 reads zero, else youngest producer wins; WB must bypass the same-cycle write.
   always_comb begin
      w_rs_data = rf_r1_data;
      if (w_rs == '0)                          w_rs_data = '0;
      else if (ex_wr_en  && ex_w_reg  == w_rs) w_rs_data = ex_w_data;
      else if (mem_wr_en && mem_w_reg == w_rs) w_rs_data = mem_w_data;
      else if (wb_wr_en  && wb_w_reg  == w_rs) w_rs_data = wb_w_data;
   end

   // rt operand: same priority as rs.
   always_comb begin
      w_rt_data = rf_r2_data;
      if (w_rt == '0)                          w_rt_data = '0;
      else if (ex_wr_en  && ex_w_reg  == w_rt) w_rt_data = ex_w_data;
      else if (mem_wr_en && mem_w_reg == w_rt) w_rt_data = mem_w_data;
      else if (wb_wr_en  && wb_w_reg  == w_rt) w_rt_data = wb_w_data;
   end

   // A load still in ID/EX has no data yet; a dependent consumer waits one cycle for MEM forwarding.
   assign w_load_use = if_valid & idex_valid & idex_is_load & (idex_rd != '0) &
                       ((w_use_rs & (w_rs == idex_rd)) | (w_use_rt & (w_rt == idex_rd)));

   // Stall is masked during reset so IF never sees a stale hold request.
   assign id_stall = rst & ~flush & (ex_hold | w_load_use);

   // ID/EX register: flush > hold > load-use bubble > normal issue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idex_valid    <= 1'b0;
         idex_pc       <= '0;
         idex_opcode   <= '0;
         idex_funct    <= '0;
         idex_rs_data  <= '0;
         idex_rt_data  <= '0;
         idex_imm      <= '0;
         idex_rd       <= '0;
         idex_wr_en    <= 1'b0;
         idex_is_load  <= 1'b0;
         idex_is_store <= 1'b0;
      end else if (flush || (!ex_hold && w_load_use)) begin
         idex_valid    <= 1'b0;
         idex_wr_en    <= 1'b0;
         idex_is_load  <= 1'b0;
         idex_is_store <= 1'b0;
      end else if (!ex_hold) begin
         idex_valid    <= if_valid;
         idex_pc       <= if_pc;
         idex_opcode   <= w_op;
         idex_funct    <= w_funct;
         idex_rs_data  <= w_rs_data;
         idex_rt_data  <= w_rt_data;
         idex_imm      <= w_imm;
         idex_rd       <= w_dest;
         idex_wr_en    <= if_valid & w_wr_en;
         idex_is_load  <= if_valid & w_is_load;
         idex_is_store <= if_valid & w_is_store;
      end
   end

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_instr, if_pc;
   logic        id_stall;
   logic [4:0]  rf_r_reg1, rf_r_reg2;
   logic [31:0] rf_r1_data, rf_r2_data;
   logic        ex_wr_en, mem_wr_en, wb_wr_en;
   logic [4:0]  ex_w_reg, mem_w_reg, wb_w_reg;
   logic [31:0] ex_w_data, mem_w_data, wb_w_data;
   logic        ex_hold, flush;
   logic        idex_valid;
   logic [31:0] idex_pc;
   logic [5:0]  idex_opcode, idex_funct;
   logic [31:0] idex_rs_data, idex_rt_data, idex_imm;
   logic [4:0]  idex_rd;
   logic        idex_wr_en, idex_is_load, idex_is_store;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_stall(id_stall), .rf_r_reg1(rf_r_reg1), .rf_r_reg2(rf_r_reg2),
      .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data),
      .ex_wr_en(ex_wr_en), .ex_w_reg(ex_w_reg), .ex_w_data(ex_w_data),
      .mem_wr_en(mem_wr_en), .mem_w_reg(mem_w_reg), .mem_w_data(mem_w_data),
      .wb_wr_en(wb_wr_en), .wb_w_reg(wb_w_reg), .wb_w_data(wb_w_data),
      .ex_hold(ex_hold), .flush(flush),
      .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_opcode(idex_opcode),
      .idex_funct(idex_funct), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
      .idex_imm(idex_imm), .idex_rd(idex_rd), .idex_wr_en(idex_wr_en),
      .idex_is_load(idex_is_load), .idex_is_store(idex_is_store)
   );

   function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_valid = 0; if_instr = 0; if_pc = 0; rf_r1_data = 0; rf_r2_data = 0;
      ex_wr_en = 0; ex_w_reg = 0; ex_w_data = 0;
      mem_wr_en = 0; mem_w_reg = 0; mem_w_data = 0;
      wb_wr_en = 0; wb_w_reg = 0; wb_w_data = 0;
      ex_hold = 0; flush = 0;
   endtask

   task automatic test_reset();
      idle();
      ex_hold = 1; if_valid = 1; if_instr = r_ins(1, 2, 3, 6'h20);
      rst = 0;
      tick(); tick();
      checks++;
      if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", id_stall); end
      checks++;
      if ({idex_valid, idex_wr_en, idex_is_load, idex_is_store, idex_pc, idex_rs_data, idex_rt_data, idex_imm, idex_rd, idex_opcode, idex_funct} !== '0) begin
         errors++; $display("FAIL reset_outputs: valid=%b pc=%h rs=%h imm=%h rd=%0d want all zero", idex_valid, idex_pc, idex_rs_data, idex_imm, idex_rd);
      end
      rst = 1;
      idle();
   endtask

   task automatic test_wb_forward();
      idle();
      wb_wr_en = 1; wb_w_reg = 3; wb_w_data = 100;
      if_valid = 1; if_instr = r_ins(3, 0, 5, 6'h20); if_pc = 32'h100;
      rf_r1_data = 999; rf_r2_data = 777;
      #1;
      checks++;
      if (rf_r_reg1 !== 5'd3 || rf_r_reg2 !== 5'd0) begin errors++; $display("FAIL rf_addr: got %0d/%0d want 3/0", rf_r_reg1, rf_r_reg2); end
      tick();
      checks++;
      if (idex_rs_data !== 32'd100) begin errors++; $display("FAIL wb_fwd: got %0d want 100", idex_rs_data); end
      checks++;
      if (idex_rt_data !== 32'd0) begin errors++; $display("FAIL r0_read: got %0d want 0", idex_rt_data); end
      checks++;
      if (idex_rd !== 5'd5 || idex_wr_en !== 1'b1 || idex_valid !== 1'b1 || idex_pc !== 32'h100) begin
         errors++; $display("FAIL add_decode: rd=%0d we=%b v=%b pc=%h want 5/1/1/100", idex_rd, idex_wr_en, idex_valid, idex_pc);
      end
   endtask

   task automatic test_priority();
      idle();
      ex_wr_en = 1; ex_w_reg = 3; ex_w_data = 7;
      mem_wr_en = 1; mem_w_reg = 3; mem_w_data = 8;
      wb_wr_en = 1; wb_w_reg = 3; wb_w_data = 9;
      if_valid = 1; if_instr = r_ins(3, 3, 6, 6'h20); rf_r1_data = 1; rf_r2_data = 2;
      tick();
      checks++;
      if (idex_rs_data !== 32'd7 || idex_rt_data !== 32'd7) begin errors++; $display("FAIL prio_ex: got %0d/%0d want 7/7", idex_rs_data, idex_rt_data); end
      ex_wr_en = 0;
      tick();
      checks++;
      if (idex_rs_data !== 32'd8) begin errors++; $display("FAIL prio_mem: got %0d want 8", idex_rs_data); end
      mem_wr_en = 0;
      tick();
      checks++;
      if (idex_rs_data !== 32'd9) begin errors++; $display("FAIL prio_wb: got %0d want 9", idex_rs_data); end
      ex_wr_en = 1; mem_wr_en = 1; ex_w_reg = 0; mem_w_reg = 0; wb_w_reg = 0;
      if_instr = r_ins(0, 0, 6, 6'h20); rf_r1_data = 32'h55; rf_r2_data = 32'h66;
      tick();
      checks++;
      if (idex_rs_data !== 32'd0 || idex_rt_data !== 32'd0) begin errors++; $display("FAIL prio_r0: got %0d/%0d want 0/0", idex_rs_data, idex_rt_data); end
   endtask

   task automatic test_load_use();
      idle();
      tick();
      if_valid = 1; if_instr = i_ins(6'h23, 1, 2, 16'd4); if_pc = 32'h200;
      tick();
      checks++;
      if (idex_is_load !== 1'b1 || idex_rd !== 5'd2 || idex_wr_en !== 1'b1) begin
         errors++; $display("FAIL lw_decode: ld=%b rd=%0d we=%b want 1/2/1", idex_is_load, idex_rd, idex_wr_en);
      end
      if_instr = r_ins(2, 2, 4, 6'h20); if_pc = 32'h204; rf_r1_data = 11; rf_r2_data = 11;
      #1;
      checks++;
      if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", id_stall); end
      tick();
      checks++;
      if (idex_valid !== 1'b0 || idex_wr_en !== 1'b0 || idex_is_load !== 1'b0) begin
         errors++; $display("FAIL lu_bubble: v=%b we=%b ld=%b want 0/0/0", idex_valid, idex_wr_en, idex_is_load);
      end
      mem_wr_en = 1; mem_w_reg = 2; mem_w_data = 55;
      #1;
      checks++;
      if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", id_stall); end
      tick();
      checks++;
      if (idex_valid !== 1'b1 || idex_rs_data !== 32'd55 || idex_rt_data !== 32'd55 || idex_rd !== 5'd4 || idex_pc !== 32'h204) begin
         errors++; $display("FAIL lu_issue: v=%b rs=%0d rt=%0d rd=%0d pc=%h want 1/55/55/4/204", idex_valid, idex_rs_data, idex_rt_data, idex_rd, idex_pc);
      end
   endtask

   task automatic test_immediates();
      idle();
      if_valid = 1; if_instr = i_ins(6'h08, 1, 2, 16'hFFFC);
      tick();
      checks++;
      if (idex_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL imm_addi: got %h want FFFFFFFC", idex_imm); end
      if_instr = i_ins(6'h0D, 1, 2, 16'hFFFC);
      tick();
      checks++;
      if (idex_imm !== 32'h0000FFFC) begin errors++; $display("FAIL imm_ori: got %h want 0000FFFC", idex_imm); end
      if_instr = {6'h03, 26'h0000010};
      tick();
      checks++;
      if (idex_rd !== 5'd31 || idex_wr_en !== 1'b1) begin errors++; $display("FAIL jal: rd=%0d we=%b want 31/1", idex_rd, idex_wr_en); end
      if_instr = i_ins(6'h2B, 1, 2, 16'd8);
      tick();
      checks++;
      if (idex_is_store !== 1'b1 || idex_wr_en !== 1'b0 || idex_is_load !== 1'b0) begin
         errors++; $display("FAIL sw: st=%b we=%b ld=%b want 1/0/0", idex_is_store, idex_wr_en, idex_is_load);
      end
   endtask

   task automatic test_flush_hold();
      idle();
      if_valid = 1; if_instr = i_ins(6'h23, 1, 2, 16'd0);
      tick();
      if_instr = r_ins(2, 2, 4, 6'h20); flush = 1; ex_hold = 1;
      #1;
      checks++;
      if (id_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", id_stall); end
      tick();
      checks++;
      if (idex_valid !== 1'b0 || idex_is_load !== 1'b0 || idex_wr_en !== 1'b0) begin
         errors++; $display("FAIL flush_bubble: v=%b ld=%b we=%b want 0/0/0", idex_valid, idex_is_load, idex_wr_en);
      end
      flush = 0; ex_hold = 0;
      if_instr = r_ins(1, 1, 7, 6'h20); if_pc = 32'h400; rf_r1_data = 32'h1234; rf_r2_data = 32'h1234;
      tick();
      ex_hold = 1; if_instr = i_ins(6'h23, 3, 9, 16'd0); if_pc = 32'h404; rf_r1_data = 32'hDEAD;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (id_stall !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d]: got %b want 1", i, id_stall); end
         tick();
         checks++;
         if (idex_valid !== 1'b1 || idex_rd !== 5'd7 || idex_rs_data !== 32'h1234 || idex_pc !== 32'h400 || idex_is_load !== 1'b0) begin
            errors++; $display("FAIL hold_stable[%0d]: v=%b rd=%0d rs=%h pc=%h want 1/7/1234/400", i, idex_valid, idex_rd, idex_rs_data, idex_pc);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      // ex_hold still asserted from the previous scenario, so the stage is stalled here.
      rst = 0;
      #1;
      checks++;
      if (idex_valid !== 1'b0 || idex_pc !== 32'h0 || idex_rs_data !== 32'h0 || idex_rd !== 5'd0 || idex_wr_en !== 1'b0) begin
         errors++; $display("FAIL async_reset: v=%b pc=%h rs=%h rd=%0d want zeros", idex_valid, idex_pc, idex_rs_data, idex_rd);
      end
      checks++;
      if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_mid: got %b want 0", id_stall); end
      tick();
      rst = 1; idle();
      if_valid = 1; if_instr = r_ins(1, 1, 0, 6'h20);
      #1;
      checks++;
      if (id_stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %b want 0", id_stall); end
      tick();
      checks++;
      if (idex_valid !== 1'b1 || idex_wr_en !== 1'b0) begin errors++; $display("FAIL rd0: v=%b we=%b want 1/0", idex_valid, idex_wr_en); end
   endtask

   // Reference model of the ID/EX contents.
   typedef struct {
      logic        valid, wr_en, is_load, is_store;
      logic [31:0] pc, imm, rs, rt;
      logic [5:0]  op, fn;
      logic [4:0]  rd;
   } idex_m_t;

   logic        src_we[3];
   logic [4:0]  src_reg[3];
   logic [31:0] src_dat[3];

   function automatic logic [31:0] m_operand(input logic [4:0] a, input logic [31:0] rf);
      if (a == 0) return 0;
      for (int s = 0; s < 3; s++)
         if (src_we[s] && src_reg[s] == a) return src_dat[s];
      return rf;
   endfunction

   function automatic void m_decode(input logic [31:0] ins, output logic [4:0] dest, output logic we,
                                    output logic [31:0] imm, output logic urs, output logic urt);
      int op;
      op = int'(ins[31:26]);
      dest = 0; we = 0;
      if (op == 0) begin dest = ins[15:11]; we = (ins[5:0] != 6'h08); end
      else if ((op >= 8 && op <= 15) || op == 35) begin dest = ins[20:16]; we = 1; end
      else if (op == 3) begin dest = 31; we = 1; end
      if (dest == 0) we = 0;
      imm = (op inside {12, 13, 14}) ? {16'h0, ins[15:0]} : 32'(signed'(ins[15:0]));
      urs = !(op inside {2, 3, 15});
      urt = (op inside {0, 4, 5, 43});
   endfunction

   task automatic test_random();
      idex_m_t m, n;
      logic [5:0] ops[14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h11};
      logic [5:0] fns[3] = '{6'h20, 6'h08, 6'h22};
      logic [4:0] dest, rs, rt;
      logic [31:0] imm;
      logic we, urs, urt, lu, exp_stall;
      m = '{default: '0};
      idle();
      rst = 0; #1; rst = 1;
      for (int c = 0; c < 400; c++) begin
         logic [5:0] op;
         op = ops[$urandom_range(0, 13)];
         if_instr = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
         if (op == 0) begin
            if_instr[15:11] = 5'($urandom_range(0, 3));
            if_instr[5:0] = fns[$urandom_range(0, 2)];
         end
         if_valid = ($urandom_range(0, 7) != 0);
         if_pc = $urandom; rf_r1_data = $urandom; rf_r2_data = $urandom;
         ex_wr_en = 1'($urandom); ex_w_reg = 5'($urandom_range(0, 3)); ex_w_data = $urandom;
         mem_wr_en = 1'($urandom); mem_w_reg = 5'($urandom_range(0, 3)); mem_w_data = $urandom;
         wb_wr_en = 1'($urandom); wb_w_reg = 5'($urandom_range(0, 3)); wb_w_data = $urandom;
         flush = ($urandom_range(0, 7) == 0);
         ex_hold = ($urandom_range(0, 5) == 0);
         src_we[0] = ex_wr_en;  src_reg[0] = ex_w_reg;  src_dat[0] = ex_w_data;
         src_we[1] = mem_wr_en; src_reg[1] = mem_w_reg; src_dat[1] = mem_w_data;
         src_we[2] = wb_wr_en;  src_reg[2] = wb_w_reg;  src_dat[2] = wb_w_data;
         #1;
         rs = if_instr[25:21]; rt = if_instr[20:16];
         m_decode(if_instr, dest, we, imm, urs, urt);
         lu = if_valid && m.valid && m.is_load && m.rd != 0 && ((urs && rs == m.rd) || (urt && rt == m.rd));
         exp_stall = !flush && (ex_hold || lu);
         checks++;
         if (id_stall !== exp_stall || rf_r_reg1 !== rs || rf_r_reg2 !== rt) begin
            errors++; $display("FAIL rnd_stall[%0d]: stall=%b r1=%0d r2=%0d want %b/%0d/%0d", c, id_stall, rf_r_reg1, rf_r_reg2, exp_stall, rs, rt);
         end
         n = m;
         if (flush || (!ex_hold && lu)) begin
            n.valid = 0; n.wr_en = 0; n.is_load = 0; n.is_store = 0;
         end else if (!ex_hold) begin
            n.valid = if_valid; n.pc = if_pc; n.op = if_instr[31:26]; n.fn = if_instr[5:0];
            n.rs = m_operand(rs, rf_r1_data); n.rt = m_operand(rt, rf_r2_data);
            n.imm = imm; n.rd = dest; n.wr_en = if_valid && we;
            n.is_load = if_valid && (if_instr[31:26] == 6'h23);
            n.is_store = if_valid && (if_instr[31:26] == 6'h2B);
         end
         tick();
         m = n;
         checks++;
         if (idex_valid !== m.valid || idex_wr_en !== m.wr_en || idex_is_load !== m.is_load || idex_is_store !== m.is_store) begin
            errors++; $display("FAIL rnd_ctrl[%0d]: v/we/ld/st=%b%b%b%b want %b%b%b%b", c, idex_valid, idex_wr_en, idex_is_load, idex_is_store, m.valid, m.wr_en, m.is_load, m.is_store);
         end
         if (m.valid) begin
            checks++;
            if (idex_pc !== m.pc || idex_opcode !== m.op || idex_funct !== m.fn || idex_imm !== m.imm ||
                idex_rs_data !== m.rs || idex_rt_data !== m.rt || (m.wr_en && idex_rd !== m.rd)) begin
               errors++; $display("FAIL rnd_data[%0d]: pc=%h rs=%h rt=%h imm=%h rd=%0d want %h/%h/%h/%h/%0d", c, idex_pc, idex_rs_data, idex_rt_data, idex_imm, idex_rd, m.pc, m.rs, m.rt, m.imm, m.rd);
            end
         end
      end
   endtask

   initial begin
      rst = 1;
      idle();
      #1;
      test_reset();
      test_wb_forward();
      test_priority();
      test_load_use();
      test_immediates();
      test_flush_hold();
      test_reset_mid_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode/operand-fetch stage of the MIPS32 pipeline. It sits between the IF/ID register and the EX stage.
- Decodes the incoming instruction and drives the read addresses of register_file, which returns read data in the same cycle.
- Resolves RAW hazards by forwarding from EX/MEM/WB, or by a one-cycle load-use stall.
- Registers decoded operands into the ID/EX pipeline register, with flush and hold handshakes.

Parameters:
DATA_W, 32, datapath and register width
REG_AW, 5, register address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
if_valid  in  1  IF/ID holds a valid instruction
if_instr  in  32  instruction word
if_pc  in  32  PC of if_instr
id_stall  out  1  IF must hold PC and IF/ID this cycle
rf_r_reg1  out  REG_AW  to register_file r_reg1 = if_instr[25:21] (rs)
rf_r_reg2  out  REG_AW  to register_file r_reg2 = if_instr[20:16] (rt)
rf_r1_data  in  DATA_W  register_file r1_data
rf_r2_data  in  DATA_W  register_file r2_data
ex_wr_en, ex_w_reg, ex_w_data  in  1/REG_AW/DATA_W  ALU result of instruction in EX
mem_wr_en, mem_w_reg, mem_w_data  in  1/REG_AW/DATA_W  MEM result, load data included
wb_wr_en, wb_w_reg, wb_w_data  in  1/REG_AW/DATA_W  same signals as register_file write port
ex_hold  in  1  EX cannot accept; ID/EX must hold
flush  in  1  taken branch/jump resolved in EX
idex_valid  out  1  ID/EX holds a real instruction
idex_pc  out  32  PC
idex_opcode  out  6  instr[31:26]
idex_funct  out  6  instr[5:0]
idex_rs_data  out  DATA_W  forwarded rs operand
idex_rt_data  out  DATA_W  forwarded rt operand
idex_imm  out  32  extended immediate
idex_rd  out  REG_AW  destination register
idex_wr_en  out  1  instruction writes idex_rd
idex_is_load  out  1  opcode 0x23 (lw)
idex_is_store  out  1  opcode 0x2B (sw)

Behaviour:
- Reset (rst=0, asynchronous): every idex_* output = 0. id_stall = 0 while in reset.
- Read addresses: rf_r_reg1 and rf_r_reg2 are combinational from if_instr, independent of if_valid.
- Decode:
  - R-type (op 0): dest = rd[15:11]; wr_en=1 except funct 0x08 (jr).
  - I-type ALU (op 0x08-0x0F) and lw: dest = rt; wr_en=1.
  - jal (op 3): dest = 31; wr_en=1.
  - All other opcodes: wr_en=0.
  - dest==0 forces wr_en=0.
- Immediate: zero-extended for op 0x0C/0x0D/0x0E; sign-extended {16{instr[15]}} otherwise.
- Source use:
  - use_rs = op not in {2,3,0x0F}.
  - use_rt = op in {0,4,5,0x2B}.
- Forwarding, per operand, combinational:
  - Address 0 always gives 0.
  - Otherwise priority is EX > MEM > WB > register file.
  - A source matches when its wr_en=1 and its w_reg equals the operand address.
  - WB forwarding is mandatory, because the register file write is not visible to a same-cycle read.
- Load-use hazard: if_valid & idex_valid & idex_is_load & idex_rd!=0 & ((use_rs & rs==idex_rd) | (use_rt & rt==idex_rd)).
- Per-edge priority (highest first):
  1. flush: ID/EX becomes a bubble (valid, wr_en, is_load, is_store = 0). id_stall=0. The IF/ID instruction is discarded by IF.
  2. ex_hold: all idex_* registers hold; id_stall=1.
  3. load-use: ID/EX gets a bubble; id_stall=1. The next cycle re-evaluates, and the load data then forwards from MEM.
  4. Otherwise: ID/EX loads the decoded instruction; idex_valid = if_valid.
- When if_valid=0, ID/EX gets a bubble. Data fields may take any value, but all control bits must be 0.
- id_stall is combinational: ~flush & (ex_hold | load_use).
- Latency: 1 cycle from IF/ID to ID/EX. A load-use pair adds exactly 1 bubble.
- Reset asserted mid-stall clears ID/EX immediately. After release, no stall persists.

Test Plan:
1. Write-then-read via WB: wb_wr_en=1, wb_w_reg=3, wb_w_data=100; instr add $5,$3,$0 -> idex_rs_data=100 next edge; idex_rd=5, idex_wr_en=1.
2. Priority: EX, MEM and WB all write r3 with values 7, 8 and 9 -> idex_rs_data=7. With EX removed -> 8. Source address 0 with all three writing r0 -> 0.
3. Load-use: lw $2,4($1) then add $4,$2,$2 -> id_stall=1 for exactly 1 cycle and one bubble (idex_valid=0). The following cycle with mem_w_data=55 -> add issues with rs and rt data = 55.
4. Immediates: addi imm 0xFFFC -> idex_imm=0xFFFFFFFC; ori imm 0xFFFC -> 0x0000FFFC; jal -> idex_rd=31, wr_en=1.
5. flush asserted together with ex_hold and a load-use hazard -> bubble, id_stall=0. ex_hold alone for 3 cycles -> idex_* stable and id_stall=1 throughout.
6. rst pulsed low mid-stall -> all idex_* outputs = 0 asynchronously and id_stall=0. An instruction with rd=0 gives wr_en=0.
